// File: rtl/m6809_alu16_seq_if.sv
// Decoder-side request/response bundle for the 16-bit accumulator sequencer.
// The decoder holds the master modport and the sequencer holds the slave modport.
interface m6809_alu16_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] d_in;
    logic [15:0] m_in;
    logic        cc_n_in;
    logic        cc_v_in;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] result;
    logic        wr_d;
    logic        c_out;
    logic        z_out;
    logic        n_out;
    logic        v_out;

    modport master (
        output start, op, d_in, m_in, cc_n_in, cc_v_in,
        input  busy, done, illegal, result, wr_d, c_out, z_out, n_out, v_out
    );

    modport slave (
        input  start, op, d_in, m_in, cc_n_in, cc_v_in,
        output busy, done, illegal, result, wr_d, c_out, z_out, n_out, v_out
    );
endinterface

// File: rtl/m6809_alu16_seq.sv
// Runs ADDD/SUBD/CMPD (and MUL when M6809_SEQ_MUL_EN is defined) byte-serially
// through one external combinational 8-bit 6809 ALU, returning a 16-bit result and N/Z/V/C.
module m6809_alu16_seq (
    input  logic                     clk,
    input  logic                     reset_n,
    m6809_alu16_seq_if.slave         req,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [3:0]               alu_op,
    output logic                     alu_op7,
    output logic                     alu_c,
    input  logic [7:0]               alu_res,
    input  logic                     alu_cy,
    input  logic                     alu_z,
    input  logic                     alu_n,
    input  logic                     alu_v
);

    localparam logic [1:0] OP_ADDD = 2'b00;
    localparam logic [1:0] OP_CMPD = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam logic [3:0] ALU_SUB = 4'h0;
    localparam logic [3:0] ALU_SBC = 4'h2;
    localparam logic [3:0] ALU_ADC = 4'h9;
    localparam logic [3:0] ALU_ADD = 4'hB;
    localparam logic [3:0] ALU_TST = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [1:0]  op_reg;
    logic [15:0] d_reg;
    logic [15:0] m_reg;
    logic [7:0]  lo_reg;
    logic        c_lo_reg;
    logic        z_lo_reg;
    logic [15:0] result_reg;
    logic        c_reg;
    logic        z_reg;
    logic        n_reg;
    logic        v_reg;
    logic        illegal_reg;
    logic        is_sub;

    assign is_sub = (op_reg != OP_ADDD);

`ifdef M6809_SEQ_MUL_EN
    logic [7:0]  acc_hi_reg;
    logic [7:0]  acc_lo_reg;
    logic [2:0]  cnt_reg;
    logic        cc_n_reg;
    logic        cc_v_reg;
    logic [15:0] mul_next;

    // One shift-add step: the 17-bit {carry, sum, acc_lo} shifted right by one.
    assign mul_next = {alu_cy, alu_res, acc_lo_reg[7:1]};
`else
    logic unused_mul_inputs;
    assign unused_mul_inputs = req.cc_n_in ^ req.cc_v_in;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req.start) begin
                    if (req.op == OP_MUL) begin
`ifdef M6809_SEQ_MUL_EN
                        state_next = S_MUL;
`else
                        state_next = S_IDLE;
`endif
                    end else begin
                        state_next = S_LO;
                    end
                end
            end
            S_LO:   state_next = S_HI;
            S_HI:   state_next = S_DONE;
`ifdef M6809_SEQ_MUL_EN
            S_MUL:  state_next = (cnt_reg == 3'd7) ? S_DONE : S_MUL;
`endif
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_op  = ALU_TST;
        alu_op7 = 1'b0;
        alu_c   = 1'b0;
        case (state_reg)
            S_LO: begin
                alu_a   = d_reg[7:0];
                alu_b   = m_reg[7:0];
                alu_op  = is_sub ? ALU_SUB : ALU_ADD;
                alu_op7 = 1'b1;
            end
            S_HI: begin
                alu_a   = d_reg[15:8];
                alu_b   = m_reg[15:8];
                alu_op  = is_sub ? ALU_SBC : ALU_ADC;
                alu_op7 = 1'b1;
                alu_c   = c_lo_reg;
            end
`ifdef M6809_SEQ_MUL_EN
            S_MUL: begin
                alu_a   = acc_hi_reg;
                alu_b   = acc_lo_reg[0] ? d_reg[15:8] : 8'h00;
                alu_op  = ALU_ADD;
                alu_op7 = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_comb begin
        req.busy    = (state_reg != S_IDLE);
        req.done    = (state_reg == S_DONE);
        req.wr_d    = (state_reg == S_DONE) && (op_reg != OP_CMPD);
        req.illegal = illegal_reg;
        req.result  = result_reg;
        req.c_out   = c_reg;
        req.z_out   = z_reg;
        req.n_out   = n_reg;
        req.v_out   = v_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_reg      <= 2'b00;
            d_reg       <= 16'h0000;
            m_reg       <= 16'h0000;
            lo_reg      <= 8'h00;
            c_lo_reg    <= 1'b0;
            z_lo_reg    <= 1'b0;
            result_reg  <= 16'h0000;
            c_reg       <= 1'b0;
            z_reg       <= 1'b0;
            n_reg       <= 1'b0;
            v_reg       <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef M6809_SEQ_MUL_EN
            acc_hi_reg  <= 8'h00;
            acc_lo_reg  <= 8'h00;
            cnt_reg     <= 3'd0;
            cc_n_reg    <= 1'b0;
            cc_v_reg    <= 1'b0;
`endif
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req.start) begin
                        if (req.op == OP_MUL) begin
`ifdef M6809_SEQ_MUL_EN
                            op_reg     <= req.op;
                            d_reg      <= req.d_in;
                            acc_hi_reg <= 8'h00;
                            acc_lo_reg <= req.d_in[7:0];
                            cnt_reg    <= 3'd0;
                            cc_n_reg   <= req.cc_n_in;
                            cc_v_reg   <= req.cc_v_in;
`else
                            illegal_reg <= 1'b1;
`endif
                        end else begin
                            op_reg <= req.op;
                            d_reg  <= req.d_in;
                            m_reg  <= req.m_in;
                        end
                    end
                end
                S_LO: begin
                    lo_reg   <= alu_res;
                    c_lo_reg <= alu_cy;
                    z_lo_reg <= alu_z;
                end
                S_HI: begin
                    result_reg <= {alu_res, lo_reg};
                    c_reg      <= alu_cy;
                    n_reg      <= alu_n;
                    v_reg      <= alu_v;
                    z_reg      <= alu_z & z_lo_reg;
                end
`ifdef M6809_SEQ_MUL_EN
                S_MUL: begin
                    acc_hi_reg <= mul_next[15:8];
                    acc_lo_reg <= mul_next[7:0];
                    cnt_reg    <= cnt_reg + 3'd1;
                    // The last step's shifted value is the finished product.
                    if (cnt_reg == 3'd7) begin
                        result_reg <= mul_next;
                        c_reg      <= mul_next[7];
                        z_reg      <= (mul_next == 16'h0000);
                        n_reg      <= cc_n_reg;
                        v_reg      <= cc_v_reg;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/m6809_alu16_seq.md
# m6809_alu16_seq

Multi-cycle sequencer that runs the 6809 16-bit accumulator operations (ADDD, SUBD, CMPD and optionally MUL) through a single shared 8-bit ALU instance. It sits between the instruction decoder and `alu8`. It drives the ALU's operand, opcode and carry inputs byte by byte and registers the partial results. It then returns a 16-bit result plus 6809 condition codes under a start/done handshake.

## Interface
Parameters: none.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 ADDD, 01 SUBD, 10 CMPD, 11 MUL.
- `d_in` in 16: D register (A = [15:8], B = [7:0]).
- `m_in` in 16: memory operand; ignored for MUL.
- `cc_n_in`, `cc_v_in` in 1 each: current N/V, passed through for MUL.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse; result and flags valid.
- `illegal` out 1: one-cycle pulse on a rejected op.
- `result` out 16: held until the next accepted start.
- `wr_d` out 1: valid with `done`; 1 for ADDD/SUBD/MUL, 0 for CMPD.
- `c_out`, `z_out`, `n_out`, `v_out` out 1 each: flags, held with `result`.
- `alu_a`, `alu_b` out 8: ALU operands.
- `alu_op` out 4, `alu_op7` out 1: ALU opcode in 6809 encoding.
- `alu_c` out 1: ALU carry/borrow in.
- `alu_res` in 8; `alu_cy`, `alu_z`, `alu_n`, `alu_v` in 1 each: ALU results.

## Operation
- States: IDLE, LO, HI, MUL, DONE.
- IDLE + `start`: latch `op`, `d_in`, `m_in` and go to LO, or to MUL if op=11.
- op=11 without MUL support: stay IDLE and pulse `illegal` next cycle.
- LO: `alu_a`=D[7:0], `alu_b`=M[7:0].
  - ADDD: ADD (0xB, op7=1), `alu_c`=0.
  - SUBD/CMPD: SUB (0x0, op7=1), `alu_c`=0.
  - Register `alu_res` as lo byte, `alu_cy` as carry, `alu_z` as z_lo. Go to HI.
- HI: `alu_a`=D[15:8], `alu_b`=M[15:8], `alu_c`=registered low carry.
  - ADDD: ADC (0x9, op7=1).
  - SUBD/CMPD: SBC (0x2, op7=1), carry treated as borrow.
  - Register the hi byte and flags:
    - C = `alu_cy`
    - N = `alu_n`
    - V = `alu_v`
    - Z = `alu_z` & z_lo
  - Go to DONE.
- MUL: unsigned A×B, shift-add over 8 iterations; 3-bit counter `cnt` counts 0..7.
  - Accumulator {acc_hi, acc_lo}: acc_hi=0, acc_lo=B at entry; multiplicand=A.
  - Each cycle: `alu_a`=acc_hi, `alu_b`=A if acc_lo[0] else 0x00; op=ADD.
  - Next {acc_hi, acc_lo} = {`alu_cy`, `alu_res`, acc_lo[7:1]}.
  - When cnt=7, go to DONE.
  - Flags: C = result[7], Z = (result==0), N = `cc_n_in`, V = `cc_v_in`, all sampled at acceptance.
- DONE: `done`=1 and `busy`=1, then go to IDLE. `start` in DONE is ignored.
- ALU drive in IDLE/DONE: `alu_op`=0xD (TST), `alu_op7`=0, operands 0, `alu_c`=0.
- Reset values: state IDLE; `busy`, `done`, `illegal`, `wr_d`, all flags, `result` = 0.
- `reset_n` low in any state (including mid-MUL): the next edge forces IDLE and reset values, and any partial result is discarded.
- `start` while busy: ignored, with no queuing.

## Timing
- Start accepted at edge E0.
- ADDD/SUBD/CMPD: LO after E0, HI after E1, `done` high in the cycle after E2. Latency 3; new start accepted at E3 or later.
- MUL: MUL for 8 cycles after E0, `done` in the cycle after E8. Latency 9.
- The ALU is combinational: outputs are sampled in the same cycle as they are driven.
- `result` and flags update on the edge entering DONE.

## Configuration
- `M6809_SEQ_MUL_EN` defined: MUL state, counter and accumulator are built, and op=11 is executed.
- `M6809_SEQ_MUL_EN` undefined: no MUL logic. op=11 pulses `illegal`, `busy` stays 0 and outputs are unchanged.

## Test plan
- ADDD: D=0x12FF, M=0x0001 -> result 0x1300, C=0, Z=0, N=0, V=0, wr_d=1, `done` 3 cycles after start.
- SUBD: D=0x0000, M=0x0001 -> 0xFFFF, C=1, N=1, Z=0, V=0.
- CMPD: D=0x8000, M=0x0001 -> 0x7FFF, V=1, N=0, C=0, wr_d=0.
- MUL (macro on): D=0xFFFF -> 0xFE01, C=0, Z=0, N/V equal to inputs, `done` 9 cycles after start. With the macro off, same stimulus -> `illegal` pulse, no `done`.
- Second `start` pulsed during HI -> ignored, exactly one `done`. `reset_n` low during MUL cycle 4 -> IDLE next edge, `result`=0, no `done`.
